// File: rtl/adder_pkg.sv
// Shared width default and a reference full-width add for the adder_unit slice.
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 4;

    // Carry-preserving add at the default width; bit WIDTH is the carry-out.
    function automatic logic [ADDER_WIDTH_DEFAULT:0] add_full(
        input logic [ADDER_WIDTH_DEFAULT-1:0] a,
        input logic [ADDER_WIDTH_DEFAULT-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_comb.sv
// Combinational WIDTH-bit ripple-carry adder with carry-out and signed overflow.
module adder_comb
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry  = '0;
        sum_o  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[WIDTH];
        // Overflow only when both operands share a sign and the result flips it.
        ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/adder_unit.sv
// Registered unsigned adder: one-cycle latency result with carry, overflow and valid.
module adder_unit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic             sum_ovf;

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    adder_comb #(.WIDTH(WIDTH)) u_adder_comb (
        .a_i    (a),
        .b_i    (b),
        .sum_o  (sum),
        .cout_o (sum_cout),
        .ovf_o  (sum_ovf)
    );

    // Result registers hold when idle; only the valid flag tracks in_valid every cycle.
    always_comb begin
        q_d     = q_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = in_valid;
        if (in_valid) begin
            q_d    = sum;
            cout_d = sum_cout;
            ovf_d  = sum_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign q         = q_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_unit.sv
// Scoreboard bench for adder_unit: directed vectors plus a random sweep, checked on out_valid.
module tb_adder_unit;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [3:0] q;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

    adder_unit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .q         (q),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector, queue its hand-computed result, and step past the sampling edge.
    task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vld,
                         input logic [3:0] eq, input logic ec, input logic eo);
        exp_t e;
        a        = va;
        b        = vb;
        in_valid = vld;
        if (vld) begin
            e.a = va; e.b = vb; e.q = eq; e.cout = ec; e.ovf = eo;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle presenting out_valid must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_out_valid: got q=%0d, expected no result", q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("a=%d, b=%d, q=%d", e.a, e.b, q);
                check("sb_q", int'(q), int'(e.q));
                check("sb_cout", int'(cout), int'(e.cout));
                check("sb_ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    // A reset discards any result that was still in flight.
    always @(negedge rst_n) sb.delete();

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ra, rb;
        logic [4:0] full;
        n_vec    = 0;
        n_miss   = 0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_q", int'(q), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        apply(4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        check("first_out_valid", int'(out_valid), 1);

        apply(4'd1, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
        apply(4'd2, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0);
        apply(4'd5, 4'd7, 1'b1, 4'd12, 1'b0, 1'b1);
        apply(4'd15, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0);
        apply(4'd8, 4'd8, 1'b1, 4'd0, 1'b1, 1'b1);
        apply(4'd7, 4'd1, 1'b1, 4'd8, 1'b0, 1'b1);
        apply(4'd3, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
        check("hold_q", int'(q), 8);
        check("hold_ovf", int'(ovf), 1);
        check("hold_out_valid", int'(out_valid), 0);

        apply(4'd9, 4'd4, 1'b1, 4'd13, 1'b0, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_q", int'(q), 0);
        check("midrst_cout", int'(cout), 0);
        check("midrst_ovf", int'(ovf), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply(4'd2, 4'd2, 1'b1, 4'd4, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            full = {1'b0, ra} + {1'b0, rb};
            apply(ra, rb, 1'b1, full[3:0], full[4],
                  (ra[3] == rb[3]) && (full[3] != ra[3]));
        end

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
